// File: rtl/ctrl_pipe_sequencer.sv
// ctrl_pipe_sequencer: 3-stage control pipeline with LM/SM micro-op expansion; expansion enabled by CTRL_PIPE_LMSM_EN
module ctrl_pipe_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [15:0] id_inst,
   input  logic [8:0]  id_ex,
   input  logic [2:0]  id_m,
   input  logic [2:0]  id_wb,
   input  logic        stall,
   input  logic        flush,
   output logic        id_ready,
   output logic        ex_valid,
   output logic [8:0]  ex_ex,
   output logic [2:0]  ex_m,
   output logic [2:0]  ex_wb,
   output logic [2:0]  ex_reg_idx,
   output logic        ex_last,
   output logic        mem_valid,
   output logic [2:0]  mem_m,
   output logic [2:0]  mem_wb,
   output logic        wb_valid,
   output logic [2:0]  wb_wb
);
   typedef enum logic {IDLE, MULTI} state_t;
   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [7:0]  rem_q, rem_d;
   logic        ex_valid_q, ex_valid_d;
   logic [8:0]  ex_ex_q, ex_ex_d;
   logic [2:0]  ex_m_q, ex_m_d;
   logic [2:0]  ex_wb_q, ex_wb_d;
   logic [2:0]  ex_idx_q, ex_idx_d;
   logic        ex_last_q, ex_last_d;
   logic        mem_valid_q, mem_valid_d;
   logic [2:0]  mem_m_q, mem_m_d;
   logic [2:0]  mem_wb_q, mem_wb_d;
   logic        wb_valid_q, wb_valid_d;
   logic [2:0]  wb_wb_q, wb_wb_d;
   logic        acc, is_lmsm, more;
   logic [7:0]  list, rest;
   logic [2:0]  lo;
   logic        unused_ok;
   assign unused_ok = ^id_inst[15:8];
   assign acc = id_valid & ready_q & ~stall & ~flush;
`ifdef CTRL_PIPE_LMSM_EN
   assign is_lmsm = (id_m == 3'b110) | (id_m == 3'b101);
`else
   assign is_lmsm = 1'b0;
`endif
   assign list = (state_q == MULTI) ? rem_q : id_inst[7:0];
   assign rest = list & (list - 8'd1);
   assign more = is_lmsm & (|rest);
   always_comb begin
      lo = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (list[i]) lo = 3'(i);
   end
   always_comb begin
      state_d     = state_q;
      ready_d     = ready_q;
      rem_d       = rem_q;
      ex_valid_d  = ex_valid_q;
      ex_ex_d     = ex_ex_q;
      ex_m_d      = ex_m_q;
      ex_wb_d     = ex_wb_q;
      ex_idx_d    = ex_idx_q;
      ex_last_d   = ex_last_q;
      mem_valid_d = stall ? mem_valid_q : ex_valid_q;
      mem_m_d     = stall ? mem_m_q : ex_m_q;
      mem_wb_d    = stall ? mem_wb_q : ex_wb_q;
      wb_valid_d  = stall ? wb_valid_q : mem_valid_q;
      wb_wb_d     = stall ? wb_wb_q : mem_wb_q;
      if (flush || (!stall && state_q == IDLE && !acc)) begin
         ex_valid_d = 1'b0;
         ex_ex_d    = '0;
         ex_m_d     = '0;
         ex_wb_d    = '0;
         ex_idx_d   = '0;
         ex_last_d  = 1'b0;
         state_d    = IDLE;
         ready_d    = 1'b1;
         rem_d      = '0;
      end else if (!stall && state_q == MULTI) begin
         ex_idx_d  = lo;
         ex_last_d = ~|rest;
         rem_d     = rest;
         state_d   = (|rest) ? MULTI : IDLE;
         ready_d   = ~|rest;
      end else if (acc) begin
         ex_valid_d = ~is_lmsm | (|list);
         ex_ex_d    = ex_valid_d ? id_ex : '0;
         ex_m_d     = ex_valid_d ? id_m : '0;
         ex_wb_d    = ex_valid_d ? id_wb : '0;
         ex_idx_d   = is_lmsm ? lo : 3'd0;
         ex_last_d  = ex_valid_d & ~more;
         rem_d      = more ? rest : '0;
         state_d    = more ? MULTI : IDLE;
         ready_d    = ~more;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         rem_q       <= '0;
         ex_valid_q  <= 1'b0;
         ex_ex_q     <= '0;
         ex_m_q      <= '0;
         ex_wb_q     <= '0;
         ex_idx_q    <= '0;
         ex_last_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_m_q     <= '0;
         mem_wb_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_wb_q     <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         rem_q       <= rem_d;
         ex_valid_q  <= ex_valid_d;
         ex_ex_q     <= ex_ex_d;
         ex_m_q      <= ex_m_d;
         ex_wb_q     <= ex_wb_d;
         ex_idx_q    <= ex_idx_d;
         ex_last_q   <= ex_last_d;
         mem_valid_q <= mem_valid_d;
         mem_m_q     <= mem_m_d;
         mem_wb_q    <= mem_wb_d;
         wb_valid_q  <= wb_valid_d;
         wb_wb_q     <= wb_wb_d;
      end
   assign id_ready   = ready_q;
   assign ex_valid   = ex_valid_q;
   assign ex_ex      = ex_ex_q;
   assign ex_m       = ex_m_q;
   assign ex_wb      = ex_wb_q;
   assign ex_reg_idx = ex_idx_q;
   assign ex_last    = ex_last_q;
   assign mem_valid  = mem_valid_q;
   assign mem_m      = mem_m_q;
   assign mem_wb     = mem_wb_q;
   assign wb_valid   = wb_valid_q;
   assign wb_wb      = wb_wb_q;
endmodule

// File: tb/tb_ctrl_pipe_sequencer.sv
// tb_ctrl_pipe_sequencer: vector table, LM/SM corner sequences and random traffic against a queue-based model
module tb_ctrl_pipe_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, stall, flush;
   logic [15:0] id_inst;
   logic [8:0]  id_ex;
   logic [2:0]  id_m, id_wb;
   logic        id_ready, ex_valid, ex_last, mem_valid, wb_valid;
   logic [8:0]  ex_ex;
   logic [2:0]  ex_m, ex_wb, ex_reg_idx, mem_m, mem_wb, wb_wb;
   int checks = 0;
   int errors = 0;
`ifdef CTRL_PIPE_LMSM_EN
   localparam bit LMSM = 1'b1;
`else
   localparam bit LMSM = 1'b0;
`endif
   localparam logic [8:0] ADD_EX = 9'b001110010;
   localparam logic [8:0] LW_EX  = 9'h011;

   ctrl_pipe_sequencer dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
      .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb), .stall(stall), .flush(flush),
      .id_ready(id_ready), .ex_valid(ex_valid), .ex_ex(ex_ex), .ex_m(ex_m),
      .ex_wb(ex_wb), .ex_reg_idx(ex_reg_idx), .ex_last(ex_last),
      .mem_valid(mem_valid), .mem_m(mem_m), .mem_wb(mem_wb),
      .wb_valid(wb_valid), .wb_wb(wb_wb)
   );

   always #5 clk = ~clk;

   // Model: an accepted bundle becomes a list of micro-ops; ID/EX pops one per free edge
   typedef struct packed {
      logic       v;
      logic [8:0] ex;
      logic [2:0] m;
      logic [2:0] wb;
      logic [2:0] idx;
      logic       last;
   } op_t;
   op_t        me;
   op_t        pend[$];
   logic       mm_v, mw_v;
   logic [2:0] mm_m, mm_wb, mw_wb;

   typedef struct {
      logic        vld;
      logic [15:0] inst;
      logic [8:0]  ex;
      logic [2:0]  m;
      logic [2:0]  wb;
      logic        st;
      logic        fl;
      logic        e_rdy;
      logic        e_ev;
      logic [2:0]  e_idx;
      logic        e_last;
      logic [2:0]  e_mem_m;
      logic [2:0]  e_mem_wb;
      logic [2:0]  e_wb_wb;
   } vec_t;
   vec_t vt[13];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      me = '0;
      pend.delete();
      mm_v = 1'b0; mm_m = '0; mm_wb = '0;
      mw_v = 1'b0; mw_wb = '0;
   endtask

   task automatic model_edge();
      op_t nx;
      if (!stall) begin
         mw_v = mm_v; mw_wb = mm_wb;
         mm_v = me.v; mm_m = me.m; mm_wb = me.wb;
      end
      if (flush) begin
         me = '0;
         pend.delete();
      end else if (!stall) begin
         if (pend.size() != 0) me = pend.pop_front();
         else if (id_valid) begin
            nx = '0;
            nx.v = 1'b1; nx.ex = id_ex; nx.m = id_m; nx.wb = id_wb; nx.last = 1'b1;
            if (LMSM && (id_m == 3'b110 || id_m == 3'b101)) begin
               for (int i = 0; i < 8; i++)
                  if (id_inst[i]) begin
                     nx.idx = 3'(i);
                     nx.last = 1'b0;
                     pend.push_back(nx);
                  end
               if (pend.size() == 0) me = '0;
               else begin
                  pend[pend.size()-1].last = 1'b1;
                  me = pend.pop_front();
               end
            end else me = nx;
         end else me = '0;
      end
   endtask

   task automatic check_model();
      chk("id_ready",   16'(id_ready),   16'(pend.size() == 0));
      chk("ex_valid",   16'(ex_valid),   16'(me.v));
      chk("ex_ex",      16'(ex_ex),      16'(me.ex));
      chk("ex_m",       16'(ex_m),       16'(me.m));
      chk("ex_wb",      16'(ex_wb),      16'(me.wb));
      chk("ex_reg_idx", 16'(ex_reg_idx), 16'(me.idx));
      chk("ex_last",    16'(ex_last),    16'(me.last));
      chk("mem_valid",  16'(mem_valid),  16'(mm_v));
      chk("mem_m",      16'(mem_m),      16'(mm_m));
      chk("mem_wb",     16'(mem_wb),     16'(mm_wb));
      chk("wb_valid",   16'(wb_valid),   16'(mw_v));
      chk("wb_wb",      16'(wb_wb),      16'(mw_wb));
   endtask

   task automatic cyc(input logic v, input logic [15:0] inst, input logic [8:0] ex,
                      input logic [2:0] m, input logic [2:0] wb, input logic st, input logic fl);
      id_valid = v; id_inst = inst; id_ex = ex; id_m = m; id_wb = wb; stall = st; flush = fl;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic idle(input logic st, input logic fl);
      cyc(1'b0, 16'h0, 9'h0, 3'b000, 3'b000, st, fl);
   endtask

   task automatic exp(input string nm, input logic rdy, input logic ev, input logic [2:0] idx, input logic last);
      chk({nm, " id_ready"},   16'(id_ready),   16'(rdy));
      chk({nm, " ex_valid"},   16'(ex_valid),   16'(ev));
      chk({nm, " ex_reg_idx"}, 16'(ex_reg_idx), 16'(idx));
      chk({nm, " ex_last"},    16'(ex_last),    16'(last));
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst ex_valid",  16'(ex_valid),  16'd0);
      chk("rst id_ready",  16'(id_ready),  16'd1);
      chk("rst ex_ex",     16'(ex_ex),     16'd0);
      chk("rst mem_valid", 16'(mem_valid), 16'd0);
      chk("rst wb_valid",  16'(wb_valid),  16'd0);
      check_model();
      #2 rst_n = 1'b1;
   endtask

   initial begin
      vt[0]  = '{1'b1, 16'h1234, ADD_EX, 3'b000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 3'b000, 3'b000, 3'b000};
      vt[1]  = '{1'b0, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000, 3'b101, 3'b000};
      vt[2]  = '{1'b0, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000, 3'b000, 3'b101};
      vt[3]  = '{1'b1, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 3'b000, 3'b000, 3'b000};
      vt[4]  = '{1'b1, 16'h4000, LW_EX,  3'b010, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 3'b000, 3'b000, 3'b000};
      vt[5]  = '{1'b0, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b010, 3'b110, 3'b000};
      vt[6]  = '{1'b1, 16'h1234, ADD_EX, 3'b000, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'b010, 3'b110, 3'b000};
      vt[7]  = '{1'b1, 16'h1234, ADD_EX, 3'b000, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b010, 3'b110, 3'b000};
      vt[8]  = '{1'b0, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000, 3'b000, 3'b110};
      vt[9]  = '{1'b1, 16'h1234, ADD_EX, 3'b000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 3'b000, 3'b000, 3'b000};
      vt[10] = '{1'b0, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 3'b000, 3'b000, 3'b000};
      vt[11] = '{1'b1, 16'h1234, ADD_EX, 3'b000, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000, 3'b101, 3'b000};
      vt[12] = '{1'b0, 16'h0000, 9'h0,   3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000, 3'b000, 3'b101};
      rst_n = 1'b1;
      id_valid = 1'b0; id_inst = '0; id_ex = '0; id_m = '0; id_wb = '0; stall = 1'b0; flush = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      model_reset();
      check_model();
      #10 rst_n = 1'b1;
      for (int i = 0; i < 13; i++) begin
         cyc(vt[i].vld, vt[i].inst, vt[i].ex, vt[i].m, vt[i].wb, vt[i].st, vt[i].fl);
         chk($sformatf("vec%0d id_ready", i),   16'(id_ready),   16'(vt[i].e_rdy));
         chk($sformatf("vec%0d ex_valid", i),   16'(ex_valid),   16'(vt[i].e_ev));
         chk($sformatf("vec%0d ex_reg_idx", i), 16'(ex_reg_idx), 16'(vt[i].e_idx));
         chk($sformatf("vec%0d ex_last", i),    16'(ex_last),    16'(vt[i].e_last));
         chk($sformatf("vec%0d mem_m", i),      16'(mem_m),      16'(vt[i].e_mem_m));
         chk($sformatf("vec%0d mem_wb", i),     16'(mem_wb),     16'(vt[i].e_mem_wb));
         chk($sformatf("vec%0d wb_wb", i),      16'(wb_wb),      16'(vt[i].e_wb_wb));
      end
`ifdef CTRL_PIPE_LMSM_EN
      cyc(1'b1, 16'h6085, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lm85 op0", 1'b0, 1'b1, 3'd0, 1'b0);
      cyc(1'b1, 16'h1111, ADD_EX, 3'b000, 3'b101, 1'b0, 1'b0); exp("lm85 op1", 1'b0, 1'b1, 3'd2, 1'b0);
      idle(1'b0, 1'b0); exp("lm85 op2", 1'b1, 1'b1, 3'd7, 1'b1);
      idle(1'b0, 1'b0); exp("lm85 end", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h700F, 9'h155, 3'b101, 3'b001, 1'b0, 1'b0); exp("sm0f op0", 1'b0, 1'b1, 3'd0, 1'b0);
      idle(1'b0, 1'b0); exp("sm0f op1", 1'b0, 1'b1, 3'd1, 1'b0);
      idle(1'b1, 1'b0); exp("sm0f stall1", 1'b0, 1'b1, 3'd1, 1'b0);
      idle(1'b1, 1'b0); exp("sm0f stall2", 1'b0, 1'b1, 3'd1, 1'b0);
      idle(1'b0, 1'b0); exp("sm0f op2", 1'b0, 1'b1, 3'd2, 1'b0);
      idle(1'b0, 1'b0); exp("sm0f op3", 1'b1, 1'b1, 3'd3, 1'b1);
      idle(1'b0, 1'b0); exp("sm0f end", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h60FF, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lmff op0", 1'b0, 1'b1, 3'd0, 1'b0);
      idle(1'b0, 1'b0); exp("lmff op1", 1'b0, 1'b1, 3'd1, 1'b0);
      idle(1'b0, 1'b0); exp("lmff op2", 1'b0, 1'b1, 3'd2, 1'b0);
      idle(1'b0, 1'b1); exp("lmff flush", 1'b1, 1'b0, 3'd0, 1'b0);
      idle(1'b0, 1'b0); exp("lmff after", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h6000, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lm zero list", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h7008, 9'h0A3, 3'b101, 3'b011, 1'b0, 1'b0); exp("sm one bit", 1'b1, 1'b1, 3'd3, 1'b1);
      idle(1'b0, 1'b0); exp("sm one bit end", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h60F0, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lmf0 op0", 1'b0, 1'b1, 3'd4, 1'b0);
      idle(1'b0, 1'b0); exp("lmf0 op1", 1'b0, 1'b1, 3'd5, 1'b0);
`else
      cyc(1'b1, 16'h6085, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lm85 single", 1'b1, 1'b1, 3'd0, 1'b1);
      cyc(1'b1, 16'h1111, ADD_EX, 3'b000, 3'b101, 1'b0, 1'b0); exp("lm85 next", 1'b1, 1'b1, 3'd0, 1'b1);
      idle(1'b0, 1'b0); exp("lm85 end", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h700F, 9'h155, 3'b101, 3'b001, 1'b0, 1'b0); exp("sm0f single", 1'b1, 1'b1, 3'd0, 1'b1);
      idle(1'b1, 1'b0); exp("sm0f stall", 1'b1, 1'b1, 3'd0, 1'b1);
      idle(1'b0, 1'b0); exp("sm0f end", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 16'h6000, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lm zero list", 1'b1, 1'b1, 3'd0, 1'b1);
      cyc(1'b1, 16'h60F0, 9'h0A3, 3'b110, 3'b011, 1'b0, 1'b0); exp("lmf0 single", 1'b1, 1'b1, 3'd0, 1'b1);
      idle(1'b0, 1'b0); exp("lmf0 end", 1'b1, 1'b0, 3'd0, 1'b0);
`endif
      async_reset();
      idle(1'b0, 1'b0); exp("post reset", 1'b1, 1'b0, 3'd0, 1'b0);
      for (int n = 0; n < 600; n++) begin
         logic [2:0]  rm;
         logic [15:0] ri;
         int          k;
         k  = $urandom_range(0, 3);
         rm = (k == 0) ? 3'b110 : (k == 1) ? 3'b101 : 3'($urandom);
         ri = 16'($urandom);
         k  = $urandom_range(0, 3);
         if (k == 0) ri[7:0] = 8'h00;
         if (k == 1) ri[7:0] = 8'(1 << $urandom_range(0, 7));
         cyc(1'($urandom_range(0, 3) != 0), ri, 9'($urandom), rm, 3'($urandom),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 14) == 0));
         if ($urandom_range(0, 99) == 0) async_reset();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
